// File: rtl/mvm_loader.sv
// Purpose : write-side loader; scatters a host word stream into the vector memory or the per-lane matrix memories.
// Latency : a beat accepted at cycle C appears on the write port at C+1; done pulses with the last write.
// Backpr. : iready is high for the whole LOAD state; ivalid gaps simply stall the counters (no skid needed).
//
// Ports: clk/rst (async active-low); start/sel_mat/vec_start_addr/mat_start_addr/num_words/num_rows_per_olane
// form the command (sampled only while busy=0); idata/ivalid/iready is the input stream; vec_* and mat_*
// are the registered memory write ports (mat_wen one-hot per lane); busy/done report command progress.
module mvm_loader #(
    parameter int VEC_ADDRW  = 8,
    parameter int MAT_ADDRW  = 9,
    parameter int VEC_SIZEW  = VEC_ADDRW + 1,
    parameter int MAT_SIZEW  = MAT_ADDRW + 1,
    parameter int NUM_OLANES = 8,
    parameter int DATAW      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sel_mat,
    input  logic [VEC_ADDRW-1:0]  vec_start_addr,
    input  logic [MAT_ADDRW-1:0]  mat_start_addr,
    input  logic [VEC_SIZEW-1:0]  num_words,
    input  logic [MAT_SIZEW-1:0]  num_rows_per_olane,
    input  logic [DATAW-1:0]      idata,
    input  logic                  ivalid,
    output logic                  iready,
    output logic [VEC_ADDRW-1:0]  vec_waddr,
    output logic [DATAW-1:0]      vec_wdata,
    output logic                  vec_wen,
    output logic [MAT_ADDRW-1:0]  mat_waddr,
    output logic [DATAW-1:0]      mat_wdata,
    output logic [NUM_OLANES-1:0] mat_wen,
    output logic                  busy,
    output logic                  done
);
    localparam int LANEW = $clog2(NUM_OLANES);

    typedef enum logic {IDLE, LOAD} state_t;
    state_t state, state_nxt;

    // latched command
    logic                 cmd_mat;
    logic [VEC_ADDRW-1:0] vbase;
    logic [MAT_ADDRW-1:0] mbase;
    logic [VEC_SIZEW-1:0] nw;
    logic [MAT_SIZEW-1:0] nr;

    // stream position
    logic [VEC_SIZEW-1:0] word;
    logic [LANEW-1:0]     lane;
    logic [MAT_SIZEW-1:0] local_row;
    logic [MAT_ADDRW-1:0] row_base;   // local_row*nw, kept incrementally

    logic accept, take_cmd, zero_cmd, word_last, lane_last, row_last, last_beat;

    assign iready    = (state == LOAD);
    assign busy      = (state == LOAD) | done;
    assign accept    = iready & ivalid;
    // the done cycle still counts as busy, so a start there is ignored
    assign take_cmd  = (state == IDLE) & ~done & start;
    assign zero_cmd  = (num_words == '0) | (sel_mat & (num_rows_per_olane == '0));
    assign word_last = (word == nw - VEC_SIZEW'(1));
    assign lane_last = &lane;   // NUM_OLANES is a power of two
    assign row_last  = (local_row == nr - MAT_SIZEW'(1));
    assign last_beat = word_last & (~cmd_mat | (lane_last & row_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_cmd && !zero_cmd) state_nxt = LOAD;
            LOAD:    if (accept && last_beat)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_mat   <= 1'b0;
            vbase     <= '0;
            mbase     <= '0;
            nw        <= '0;
            nr        <= '0;
            word      <= '0;
            lane      <= '0;
            local_row <= '0;
            row_base  <= '0;
            vec_waddr <= '0;
            vec_wdata <= '0;
            vec_wen   <= 1'b0;
            mat_waddr <= '0;
            mat_wdata <= '0;
            mat_wen   <= '0;
            done      <= 1'b0;
        end else begin
            vec_wen <= 1'b0;
            mat_wen <= '0;
            done    <= 1'b0;

            if (take_cmd) begin
                cmd_mat   <= sel_mat;
                vbase     <= vec_start_addr;
                mbase     <= mat_start_addr;
                nw        <= num_words;
                nr        <= num_rows_per_olane;
                word      <= '0;
                lane      <= '0;
                local_row <= '0;
                row_base  <= '0;
                if (zero_cmd) done <= 1'b1;
            end

            if (accept) begin
                if (cmd_mat) begin
                    mat_waddr     <= mbase + row_base + MAT_ADDRW'(word);
                    mat_wdata     <= idata;
                    mat_wen[lane] <= 1'b1;
                end else begin
                    vec_waddr <= vbase + VEC_ADDRW'(word);
                    vec_wdata <= idata;
                    vec_wen   <= 1'b1;
                end

                // word -> lane -> local_row carry chain; row_base advances once per lane wrap
                if (word_last) begin
                    word <= '0;
                    lane <= lane + LANEW'(1);
                    if (lane_last) begin
                        local_row <= local_row + MAT_SIZEW'(1);
                        row_base  <= row_base + MAT_ADDRW'(nw);
                    end
                end else begin
                    word <= word + VEC_SIZEW'(1);
                end

                if (last_beat) done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mvm_loader.sv
// Purpose : randomized self-checking bench for mvm_loader against a write-list reference model.
// Latency : model expects each accepted beat's write one cycle after acceptance, done with the last write.
// Backpr. : ivalid is driven with fixed and random gap patterns; iready is predicted by the model.
module tb_mvm_loader;
    localparam int VA = 8, MA = 9, VS = 9, MS = 10, NL = 8, DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          sel_mat = 1'b0;
    logic [VA-1:0] vec_start_addr = '0;
    logic [MA-1:0] mat_start_addr = '0;
    logic [VS-1:0] num_words = '0;
    logic [MS-1:0] num_rows_per_olane = '0;
    logic [DW-1:0] idata = '0;
    logic          ivalid = 1'b0;
    logic          iready;
    logic [VA-1:0] vec_waddr;
    logic [DW-1:0] vec_wdata;
    logic          vec_wen;
    logic [MA-1:0] mat_waddr;
    logic [DW-1:0] mat_wdata;
    logic [NL-1:0] mat_wen;
    logic          busy;
    logic          done;

    mvm_loader #(
        .VEC_ADDRW(VA), .MAT_ADDRW(MA), .VEC_SIZEW(VS), .MAT_SIZEW(MS),
        .NUM_OLANES(NL), .DATAW(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sel_mat(sel_mat),
        .vec_start_addr(vec_start_addr), .mat_start_addr(mat_start_addr),
        .num_words(num_words), .num_rows_per_olane(num_rows_per_olane),
        .idata(idata), .ivalid(ivalid), .iready(iready),
        .vec_waddr(vec_waddr), .vec_wdata(vec_wdata), .vec_wen(vec_wen),
        .mat_waddr(mat_waddr), .mat_wdata(mat_wdata), .mat_wen(mat_wen),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a command expands into the ordered list of writes it must produce.
    typedef struct {
        bit mat;
        int lane;
        int addr;
    } wr_t;

    wr_t q[$];
    bit  m_load = 0;   // model: LOAD in the current cycle
    bit  m_done = 0;   // model: done in the current cycle
    int  beats  = 0;

    task automatic build_cmd(input bit mat, input int vb, input int mb, input int nw, input int nr);
        wr_t w;
        q.delete();
        if (nw == 0 || (mat && nr == 0)) return;
        if (!mat) begin
            for (int k = 0; k < nw; k++) begin
                w.mat = 0; w.lane = 0; w.addr = (vb + k) % (1 << VA);
                q.push_back(w);
            end
        end else begin
            // global row g = r*NL + l, rows streamed in g order
            for (int r = 0; r < nr; r++)
                for (int l = 0; l < NL; l++)
                    for (int k = 0; k < nw; k++) begin
                        w.mat = 1; w.lane = l; w.addr = (mb + r * nw + k) % (1 << MA);
                        q.push_back(w);
                    end
        end
    endtask

    // Drive one cycle (called at negedge), predict the edge, then check the next cycle's outputs.
    task automatic tick(input bit st, input bit v);
        bit            e_done = 0;
        bit            e_vw = 0;
        logic [NL-1:0] e_mw = '0;
        int            e_addr = 0;
        logic [DW-1:0] e_dat = '0;
        bit            load_n = m_load;
        wr_t           w;
        start  = st;
        ivalid = v;
        idata  = {$urandom, $urandom};
        if (!m_load && !m_done && st) begin
            build_cmd(sel_mat, int'(vec_start_addr), int'(mat_start_addr),
                      int'(num_words), int'(num_rows_per_olane));
            if (q.size() == 0) e_done = 1;
            else               load_n = 1;
        end else if (m_load && v) begin
            w = q.pop_front();
            beats++;
            if (w.mat) e_mw[w.lane] = 1'b1;
            else       e_vw = 1;
            e_addr = w.addr;
            e_dat  = idata;
            if (q.size() == 0) begin
                e_done = 1;
                load_n = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        m_load = load_n;
        m_done = e_done;
        check("iready", iready, m_load);
        check("busy", busy, m_load | e_done);
        check("done", done, e_done);
        check("vec_wen", vec_wen, e_vw);
        check("mat_wen", mat_wen, e_mw);
        if (e_vw) begin
            check("vec_waddr", vec_waddr, e_addr);
            check("vec_wdata", vec_wdata, e_dat);
        end
        if (|e_mw) begin
            check("mat_waddr", mat_waddr, e_addr);
            check("mat_wdata", mat_wdata, e_dat);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_iready"}, iready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_vec_wen"}, vec_wen, 0);
        check({tag, "_mat_wen"}, mat_wen, 0);
        check({tag, "_vec_waddr"}, vec_waddr, 0);
        check({tag, "_vec_wdata"}, vec_wdata, 0);
        check({tag, "_mat_waddr"}, mat_waddr, 0);
        check({tag, "_mat_wdata"}, mat_wdata, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_all_zero("rst");
        m_load = 0;
        m_done = 0;
        q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // mode: 0 ivalid always high, 1 pattern 1,0,0,1, 2 random with stray starts, 3 one start mid-load
    task automatic run_cmd(input bit mat, input int vb, input int mb, input int nw, input int nr,
                           input int mode, input int abort_at);
        int n = 0;
        bit v, st;
        sel_mat            = mat;
        vec_start_addr     = VA'(vb);
        mat_start_addr     = MA'(mb);
        num_words          = VS'(nw);
        num_rows_per_olane = MS'(nr);
        beats = 0;
        tick(1, 0);
        while ((m_load || m_done) && n < 4000) begin
            if (abort_at >= 0 && beats == abort_at) begin
                do_reset();
                return;
            end
            case (mode)
                1:       v = (n % 4 == 0) || (n % 4 == 3);
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1;
            endcase
            st = (mode == 2) ? ($urandom_range(0, 3) == 0) : (mode == 3 && n == 2);
            if (st) begin
                sel_mat            = ~sel_mat;
                vec_start_addr     = VA'($urandom);
                mat_start_addr     = MA'($urandom);
                num_words          = VS'($urandom_range(1, 6));
                num_rows_per_olane = MS'($urandom_range(1, 3));
            end
            tick(st, v);
            n++;
        end
        check("cmd_finished", m_load | m_done, 0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_cmd(0, 10, 0, 4, 0, 0, -1);      // vector 10..13
        run_cmd(1, 0, 5, 2, 2, 0, -1);       // matrix, 32 beats
        run_cmd(1, 0, 5, 2, 2, 1, -1);       // matrix with ivalid 1,0,0,1
        run_cmd(0, 3, 0, 0, 0, 0, -1);       // zero words
        run_cmd(1, 0, 7, 3, 0, 0, -1);       // matrix with zero rows
        run_cmd(1, 0, 100, 3, 1, 3, -1);     // start while busy ignored
        run_cmd(0, 20, 0, 6, 0, 3, -1);      // start while busy, vector
        run_cmd(1, 0, 40, 2, 2, 0, 3);       // reset after 3 beats
        run_cmd(0, 30, 0, 5, 0, 0, -1);      // new command from word 0
        run_cmd(0, 254, 0, 4, 0, 0, -1);     // vector address wrap
        run_cmd(1, 0, 510, 3, 1, 0, -1);     // matrix address wrap
        for (int i = 0; i < 30; i++)
            run_cmd($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 511),
                    $urandom_range(0, 5), $urandom_range(0, 3), 2, -1);
        for (int i = 0; i < 4; i++) tick(0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
